// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexing scan controller for an 8-digit
// seven-segment display. Holds eight 4-bit digit values and steps a
// 3-bit digit select through 0..7, holding each digit REFRESH_DIV cycles.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   we         digit write strobe
//   waddr      digit index to write (0..7)
//   wdata      digit value (0x0..0xF)
//   digit_en   per-digit enable mask, bit i = 0 blanks digit i
//   sel        current digit index (registered)
//   num        value of digit sel (registered, write bypassed)
//   blank      current digit must be dark (registered)
//   tick       one-cycle pulse when sel advances
//   frame_done one-cycle pulse when sel wraps 7 -> 0
//
// Optional feature: define SEG_SCAN_LZ_BLANK_EN to enable leading-zero
// blanking (digits above the most significant non-zero digit go dark,
// digit 0 is always shown).

module seg_scan_ctrl #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [2:0] waddr,
    input  logic [3:0] wdata,
    input  logic [7:0] digit_en,
    output logic [2:0] sel,
    output logic [3:0] num,
    output logic       blank,
    output logic       tick,
    output logic       frame_done
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

    logic [3:0]    mem      [8];
    logic [3:0]    mem_next [8];
    logic [CW-1:0] cnt;
    logic          adv;
    logic [2:0]    sel_next;
    logic [7:0]    zero_sfx;
    logic          blank_next;

    assign adv      = (cnt == LAST);
    assign sel_next = adv ? sel + 3'd1 : sel;

    // Store contents as they will be after this edge; reading num from
    // here gives the write bypass for free.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            mem_next[i] = mem[i];
        end
        if (we) begin
            mem_next[waddr] = wdata;
        end
    end

    // zero_sfx[i] = 1 when every digit at index >= i is zero.
    always_comb begin
        logic run;
        run      = 1'b1;
        zero_sfx = '0;
        for (int i = 7; i >= 0; i--) begin
            run         = run && (mem_next[i] == 4'd0);
            zero_sfx[i] = run;
        end
    end

`ifdef SEG_SCAN_LZ_BLANK_EN
    assign blank_next = ~digit_en[sel_next]
                      | ((sel_next != 3'd0) & zero_sfx[sel_next]);
`else
    assign blank_next = ~digit_en[sel_next];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            sel        <= '0;
            num        <= '0;
            blank      <= 1'b0;
            tick       <= 1'b0;
            frame_done <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                mem[i] <= '0;
            end
        end else begin
            cnt        <= adv ? '0 : cnt + 1'b1;
            sel        <= sel_next;
            num        <= mem_next[sel_next];
            blank      <= blank_next;
            tick       <= adv;
            frame_done <= adv && (sel == 3'd7);
            for (int i = 0; i < 8; i++) begin
                mem[i] <= mem_next[i];
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed self-checking bench for seg_scan_ctrl
// with REFRESH_DIV=4.

module tb_seg_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       we;
    logic [2:0] waddr;
    logic [3:0] wdata;
    logic [7:0] digit_en;
    logic [2:0] sel;
    logic [3:0] num;
    logic       blank;
    logic       tick;
    logic       frame_done;

    int total = 0;
    int bad   = 0;
    int k     = 0;   // edges since reset release

    seg_scan_ctrl #(.REFRESH_DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .digit_en   (digit_en),
        .sel        (sel),
        .num        (num),
        .blank      (blank),
        .tick       (tick),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s k=%0d observed=%0h expected=%0h",
                   tag, k, obs, exp);
        end
    endtask

    function automatic logic [2:0] exp_sel();
        return 3'((k / 4) % 8);
    endfunction

    // sel/tick/frame_done follow directly from the edge count k
    task automatic chk_scan;
        chk("sel", 8'(sel), 8'(exp_sel()));
        chk("tick", 8'(tick), 8'(k > 0 && k % 4 == 0));
        chk("frame_done", 8'(frame_done), 8'(k > 0 && k % 32 == 0));
    endtask

    initial begin
        rst      = 1'b1;
        we       = 1'b0;
        waddr    = 3'd0;
        wdata    = 4'd0;
        digit_en = 8'hFF;
        step;
        // write during reset must be ignored
        we    = 1'b1;
        waddr = 3'd0;
        wdata = 4'hF;
        step;
        we = 1'b0;
        chk("rst_sel", 8'(sel), 8'd0);
        chk("rst_num", 8'(num), 8'd0);
        chk("rst_blank", 8'(blank), 8'd0);
        chk("rst_tick", 8'(tick), 8'd0);
        chk("rst_fd", 8'(frame_done), 8'd0);

        rst = 1'b0;
        k   = 0;
        step;
        chk_scan;
        chk("num_d0_after_rst_we", 8'(num), 8'd0);
        while (k < 40) begin
            step;
            chk_scan;
        end

        // write 3 to digit 5 while digit 2 is shown
        we    = 1'b1;
        waddr = 3'd5;
        wdata = 4'h3;
        step;
        we = 1'b0;
        chk_scan;
        chk("num_d2", 8'(num), 8'd0);
        while (k < 51) begin
            step;
            chk_scan;
        end
        chk("num_d4_pre", 8'(num), 8'd0);
        step;
        chk_scan;
        chk("num_d5", 8'(num), 8'h3);

        // write digit 4 in the sel=3, adv=1 cycle: bypass
        while (k < 79) begin
            step;
            chk_scan;
        end
        we    = 1'b1;
        waddr = 3'd4;
        wdata = 4'hA;
        step;
        we = 1'b0;
        chk_scan;
        chk("bypass_num", 8'(num), 8'hA);

        // mask digit 3 for a full frame
        digit_en = 8'b1111_0111;
        while (k < 112) begin
            step;
            chk_scan;
            chk("mask_blank", 8'(blank), 8'(exp_sel() == 3'd3));
            chk("frame_num", 8'(num),
                (exp_sel() == 3'd5) ? 8'h3 :
                (exp_sel() == 3'd4) ? 8'hA : 8'h0);
        end
        digit_en = 8'hFF;
        step;
        chk("unmask_blank", 8'(blank), 8'd0);

        // reset mid-scan at sel=6, cnt=2
        while (k < 154) begin
            step;
            chk_scan;
        end
        rst   = 1'b1;
        we    = 1'b1;
        waddr = 3'd5;
        wdata = 4'h9;
        step;
        rst = 1'b0;
        we  = 1'b0;
        chk("mid_rst_sel", 8'(sel), 8'd0);
        chk("mid_rst_num", 8'(num), 8'd0);
        chk("mid_rst_blank", 8'(blank), 8'd0);
        chk("mid_rst_tick", 8'(tick), 8'd0);
        chk("mid_rst_fd", 8'(frame_done), 8'd0);
        k = 0;
        repeat (24) begin
            step;
            chk_scan;
            chk("cleared_num", 8'(num), 8'd0);
        end

`ifdef SEG_SCAN_LZ_BLANK_EN
        // digits {7..0} = 0,0,0,0,1,2,0,0
        we    = 1'b1;
        waddr = 3'd3;
        wdata = 4'h1;
        step;
        chk_scan;
        waddr = 3'd2;
        wdata = 4'h2;
        step;
        we = 1'b0;
        chk_scan;
        repeat (32) begin
            step;
            chk_scan;
            chk("lz_blank", 8'(blank), 8'(exp_sel() >= 3'd4));
        end
        we    = 1'b1;
        waddr = 3'd2;
        wdata = 4'h0;
        step;
        waddr = 3'd3;
        step;
        we = 1'b0;
        repeat (32) begin
            step;
            chk_scan;
            chk("lz_zero_blank", 8'(blank), 8'(exp_sel() != 3'd0));
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
